// File: rtl/jacobi_row_sequencer_if.sv
// Handshake and strobe bundle between the Jacobi row sequencer, the MAC stage,
// the I subtract/accumulate datapath and the result writeback path.
interface jacobi_row_sequencer_if #(
  parameter int TERM_W = 4
);
  logic              enable;
  logic              start;
  logic              prod_valid;
  logic [47:0]       result_I_minus_Accum;
  logic              result_ready;
  logic              busy;
  logic              accum_clear;
  logic              accum_en;
  logic              term_req;
  logic [TERM_W-1:0] term_idx;
  logic              get_I_flag;
  logic [1:0]        I_value_select;
  logic [47:0]       result_data;
  logic [1:0]        result_row;
  logic              result_valid;
  logic              done;

  modport master (
    input  enable, start, prod_valid, result_I_minus_Accum, result_ready,
    output busy, accum_clear, accum_en, term_req, term_idx, get_I_flag,
           I_value_select, result_data, result_row, result_valid, done
  );

  modport slave (
    output enable, start, prod_valid, result_I_minus_Accum, result_ready,
    input  busy, accum_clear, accum_en, term_req, term_idx, get_I_flag,
           I_value_select, result_data, result_row, result_valid, done
  );
endinterface

// File: rtl/jacobi_row_sequencer.sv
// Sequences clear / accumulate / load-I / subtract / writeback for the four
// rows of one Jacobi block.
module jacobi_row_sequencer #(
  parameter int N_TERMS = 4,
  parameter int TERM_W  = 4
) (
  input logic                    clock,
  input logic                    reset,
  jacobi_row_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    LOAD_I = 3'd3,
    SUB    = 3'd4,
    WB     = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(N_TERMS - 1);
  localparam logic [TERM_W-1:0] TERM_ZERO = {TERM_W{1'b0}};
  localparam logic [TERM_W-1:0] TERM_ONE  = TERM_W'(1);

  state_t            state_r;
  state_t            state_s;
  logic [1:0]        row_r;
  logic [TERM_W-1:0] term_idx_r;
  logic [47:0]       result_data_r;
  logic              busy_r;
  logic              accum_clear_r;
  logic              term_req_r;
  logic              get_I_flag_r;
  logic              result_valid_r;
  logic              done_r;

  // Next-state decode; a low enable overrides every state and returns to IDLE.
  always_comb begin
    state_s = state_r;
    if (!bus.enable) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = bus.start ? CLEAR : IDLE;
        CLEAR:   state_s = ACCUM;
        ACCUM:   state_s = (bus.prod_valid && (term_idx_r == LAST_TERM)) ? LOAD_I : ACCUM;
        LOAD_I:  state_s = SUB;
        SUB:     state_s = WB;
        WB: begin
          if (bus.result_ready) begin
            state_s = (row_r == 2'd3) ? DONE : CLEAR;
          end else begin
            state_s = WB;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register with strobes registered from the next state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      accum_clear_r  <= 1'b0;
      term_req_r     <= 1'b0;
      get_I_flag_r   <= 1'b0;
      result_valid_r <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      busy_r         <= (state_s != IDLE);
      accum_clear_r  <= (state_s == CLEAR);
      term_req_r     <= (state_s == ACCUM);
      get_I_flag_r   <= (state_s == LOAD_I);
      result_valid_r <= (state_s == WB);
      done_r         <= (state_s == DONE);
    end
  end

  // Term index: zeroed on every row entry, saturates at the last term.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      term_idx_r <= TERM_ZERO;
    end else if (!bus.enable) begin
      term_idx_r <= TERM_ZERO;
    end else if (state_s == CLEAR) begin
      term_idx_r <= TERM_ZERO;
    end else if ((state_r == ACCUM) && bus.prod_valid && (term_idx_r != LAST_TERM)) begin
      term_idx_r <= term_idx_r + TERM_ONE;
    end else begin
      term_idx_r <= term_idx_r;
    end
  end

  // Row counter advances only when a non-final row's result is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_r <= 2'd0;
    end else if (!bus.enable) begin
      row_r <= 2'd0;
    end else if ((state_r == IDLE) && bus.start) begin
      row_r <= 2'd0;
    end else if ((state_r == WB) && bus.result_ready && (row_r != 2'd3)) begin
      row_r <= row_r + 2'd1;
    end else begin
      row_r <= row_r;
    end
  end

  // Result capture at the end of SUB; held through WB until accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_data_r <= 48'd0;
    end else if (!bus.enable) begin
      result_data_r <= 48'd0;
    end else if (state_r == SUB) begin
      result_data_r <= bus.result_I_minus_Accum;
    end else begin
      result_data_r <= result_data_r;
    end
  end

  // accum_en must follow prod_valid within the same cycle, so it stays combinational.
  assign bus.accum_en       = term_req_r & bus.prod_valid;
  assign bus.busy           = busy_r;
  assign bus.accum_clear    = accum_clear_r;
  assign bus.term_req       = term_req_r;
  assign bus.term_idx       = term_idx_r;
  assign bus.get_I_flag     = get_I_flag_r;
  assign bus.I_value_select = row_r;
  assign bus.result_data    = result_data_r;
  assign bus.result_row     = row_r;
  assign bus.result_valid   = result_valid_r;
  assign bus.done           = done_r;

endmodule

// File: tb/tb_jacobi_row_sequencer.sv
// Scenario bench for jacobi_row_sequencer: a scoreboard of expected results
// plus a negedge monitor that logs cycle positions of the key events.
module tb_jacobi_row_sequencer;

  localparam int N_TERMS = 4;
  localparam int TERM_W  = 4;

  logic clock;
  logic reset;
  jacobi_row_sequencer_if #(.TERM_W(TERM_W)) bus ();

  jacobi_row_sequencer #(.N_TERMS(N_TERMS), .TERM_W(TERM_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;
  int pos_count;
  int k_edge;
  logic [47:0] data_base;

  logic [49:0] exp_q [$];
  int valid_log [$];
  int done_log [$];
  int sel_log [$];
  int accum_cnt [4];
  int stall_cnt;

  always @(posedge clock) pos_count <= pos_count + 1;

  // Subtractor model: result tracks the currently selected row.
  always_comb bus.result_I_minus_Accum = data_base + 48'(bus.I_value_select);

  function automatic logic [62:0] out_vec();
    return {bus.busy, bus.accum_clear, bus.accum_en, bus.term_req, bus.get_I_flag,
            bus.result_valid, bus.done, bus.term_idx, bus.I_value_select,
            bus.result_row, bus.result_data};
  endfunction

  // Monitor state
  int          mon_rel;
  logic [49:0] mon_got;
  logic [49:0] mon_exp;
  logic [49:0] prev_res;
  logic        prev_valid;
  logic        prev_ready;
  logic        prev_last;
  int          exp_term;

  always @(negedge clock) begin
    mon_rel = pos_count + 1 - k_edge;
    mon_got = {bus.result_row, bus.result_data};
    if (bus.result_valid && !prev_valid) valid_log.push_back(mon_rel);
    if (bus.result_valid && prev_valid && !prev_ready) begin
      checks++;
      if (mon_got !== prev_res) begin
        errors++;
        $display("FAIL wb_hold: got %h required %h", mon_got, prev_res);
      end
    end
    if (bus.result_valid && !bus.result_ready) stall_cnt++;
    if (bus.result_valid && bus.result_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got %h required no result", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL result: got row/data %h required %h", mon_got, mon_exp);
        end
      end
    end
    if (bus.done) done_log.push_back(mon_rel);
    if (bus.accum_clear) exp_term = 0;
    if (bus.accum_en) begin
      checks++;
      if (int'(bus.term_idx) !== exp_term) begin
        errors++;
        $display("FAIL term_idx: got %0d required %0d", bus.term_idx, exp_term);
      end
      exp_term++;
      accum_cnt[bus.I_value_select]++;
    end
    if (bus.get_I_flag) begin
      sel_log.push_back(int'(bus.I_value_select));
      checks++;
      if (!prev_last) begin
        errors++;
        $display("FAIL get_I_timing: got get_I_flag without last accum_en one cycle earlier, required it");
      end
    end
    checks++;
    if (($countones({bus.accum_clear, bus.term_req, bus.get_I_flag, bus.result_valid, bus.done}) > 1)
        || (bus.accum_en && !bus.term_req)) begin
      errors++;
      $display("FAIL strobe_exclusive: got clr/req/en/getI/valid/done %b required one-hot",
               {bus.accum_clear, bus.term_req, bus.accum_en, bus.get_I_flag, bus.result_valid, bus.done});
    end
    prev_valid = bus.result_valid;
    prev_ready = bus.result_ready;
    prev_res   = mon_got;
    prev_last  = bus.accum_en && (int'(bus.term_idx) == N_TERMS - 1);
  end

  task automatic start_pass(input logic [47:0] base);
    data_base = base;
    valid_log.delete();
    done_log.delete();
    sel_log.delete();
    for (int r = 0; r < 4; r++) accum_cnt[r] = 0;
    stall_cnt = 0;
    for (int r = 0; r < 4; r++) exp_q.push_back({2'(r), base + 48'(r)});
    @(posedge clock); #1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    k_edge = pos_count;
    bus.start = 1'b0;
  endtask

  task automatic go_to_rel(input int target);
    for (int i = 0; i < 200; i++) begin
      if (pos_count + 1 - k_edge >= target) break;
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_log.size() > 0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    repeat (4) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (out_vec() !== 63'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", out_vec());
    end
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got busy %b required 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    bit seen;
    int exp_v[4];
    exp_v = '{8, 16, 24, 32};
    start_pass(48'h100);
    wait_done(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL basic_timeout: got no done required done");
    end
    checks++;
    if (valid_log.size() != 4) begin
      errors++;
      $display("FAIL basic_valid_count: got %0d required 4", valid_log.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (valid_log[r] != exp_v[r]) begin
          errors++;
          $display("FAIL basic_valid_cycle row %0d: got %0d required %0d", r, valid_log[r], exp_v[r]);
        end
      end
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != 33) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses first at %0d required 1 at 33",
               done_log.size(), (done_log.size() > 0) ? done_log[0] : -1);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (accum_cnt[r] != N_TERMS) begin
        errors++;
        $display("FAIL basic_accum_en row %0d: got %0d required %0d", r, accum_cnt[r], N_TERMS);
      end
    end
    checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got %0d pending busy %b required 0 pending busy 0", exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_prod_stall();
    bit seen;
    int exp_v[4];
    exp_v = '{8, 19, 27, 35};
    start_pass(48'h2000);
    go_to_rel(11);
    bus.prod_valid = 1'b0;
    go_to_rel(14);
    bus.prod_valid = 1'b1;
    wait_done(seen);
    checks++;
    if (!seen || done_log[0] != 36) begin
      errors++;
      $display("FAIL stall_done: got seen %b at %0d required 36", seen,
               (done_log.size() > 0) ? done_log[0] : -1);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (accum_cnt[r] != N_TERMS || valid_log.size() != 4 || valid_log[r] != exp_v[r]) begin
        errors++;
        $display("FAIL stall_row %0d: got accum %0d valid_at %0d required %0d at %0d", r, accum_cnt[r],
                 (valid_log.size() > r) ? valid_log[r] : -1, N_TERMS, exp_v[r]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    start_pass(48'h3000);
    go_to_rel(24);
    bus.result_ready = 1'b0;
    go_to_rel(29);
    bus.result_ready = 1'b1;
    wait_done(seen);
    checks++;
    if (!seen || done_log[0] != 38) begin
      errors++;
      $display("FAIL bp_done: got seen %b at %0d required 38", seen,
               (done_log.size() > 0) ? done_log[0] : -1);
    end
    checks++;
    if (stall_cnt != 5) begin
      errors++;
      $display("FAIL bp_stall_cycles: got %0d required 5", stall_cnt);
    end
    checks++;
    if (valid_log.size() != 4 || valid_log[2] != 24 || valid_log[3] != 37) begin
      errors++;
      $display("FAIL bp_valid_cycles: got %0d entries required row2 at 24 row3 at 37", valid_log.size());
    end
  endtask

  task automatic test_select_order();
    bit seen;
    start_pass(48'(($urandom() << 8)) | 48'h55);
    for (int i = 0; i < 300; i++) begin
      if (done_log.size() > 0) break;
      bus.prod_valid = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    bus.prod_valid = 1'b1;
    wait_done(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL select_timeout: got no done required done");
    end
    checks++;
    if (sel_log.size() != 4) begin
      errors++;
      $display("FAIL select_count: got %0d required 4", sel_log.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (sel_log[r] != r) begin
          errors++;
          $display("FAIL select_order %0d: got %0d required %0d", r, sel_log[r], r);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    bit seen;
    start_pass(48'h4000);
    go_to_rel(12);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_done(seen);
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (!seen || done_log.size() != 1 || valid_log.size() != 4 || exp_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: got done %0d results %0d pending %0d busy %b required 1 4 0 0",
               done_log.size(), valid_log.size(), exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_abort_enable();
    bit seen;
    start_pass(48'h5000);
    go_to_rel(19);
    bus.enable = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.term_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_precondition: got term_req %b required 1", bus.term_req);
    end
    @(negedge clock);
    checks++;
    if (out_vec() !== 63'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %h required 0", out_vec());
    end
    #1;
    bus.enable = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (done_log.size() != 0 || exp_q.size() != 2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done %0d pending %0d busy %b required 0 2 0",
               done_log.size(), exp_q.size(), bus.busy);
    end
    exp_q.delete();
    start_pass(48'h5100);
    wait_done(seen);
    checks++;
    if (!seen || done_log[0] != 33 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_restart: got seen %b pending %0d required done at 33", seen, exp_q.size());
    end
  endtask

  task automatic test_reset_wb();
    bit seen;
    start_pass(48'h6000);
    go_to_rel(8);
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_wb_precondition: got result_valid %b required 1", bus.result_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_vec() !== 63'd0) begin
      errors++;
      $display("FAIL reset_wb_outputs: got %h required 0", out_vec());
    end
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (done_log.size() != 0 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL reset_wb_discard: got done %0d pending %0d required 0 4", done_log.size(), exp_q.size());
    end
    exp_q.delete();
    start_pass(48'h6100);
    wait_done(seen);
    checks++;
    if (!seen || done_log[0] != 33 || valid_log.size() != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_restart: got seen %b results %0d pending %0d required done at 33 with 4 results",
               seen, valid_log.size(), exp_q.size());
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    k_edge           = 0;
    exp_term         = 0;
    stall_cnt        = 0;
    prev_valid       = 1'b0;
    prev_ready       = 1'b0;
    prev_last        = 1'b0;
    prev_res         = 50'd0;
    data_base        = 48'h100;
    reset            = 1'b0;
    bus.enable       = 1'b0;
    bus.start        = 1'b0;
    bus.prod_valid   = 1'b1;
    bus.result_ready = 1'b1;
    test_reset();
    test_basic();
    test_prod_stall();
    test_backpressure();
    test_select_order();
    test_start_busy();
    test_abort_enable();
    test_reset_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
